axi4lite_slave_regfile: RTL
===========================

AXI4LITE_SLAVE_REGFILE -- requirements
Module: axi4lite_slave_regfile

Interface
REQ-001 The block SHALL have parameter ADDRWIDTH, default 32, meaning the width of AWADDR and ARADDR.
REQ-002 The block SHALL have parameter DATAWIDTH, default 32, meaning the width of WDATA, RDATA and each register.
REQ-003 The block SHALL have parameter NREGS, default 16 (power of 2, range 2..256), meaning the number of registers.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset; the ports SHALL be ACLK (input, 1, rising-edge clock) and ARESET (input, 1, synchronous active-high reset).
REQ-005 The port AWADDR SHALL be an input of width ADDRWIDTH carrying the write address.
REQ-006 The ports AWVALID (input, 1) and AWREADY (output, 1) SHALL form the write-address handshake.
REQ-007 The port WDATA SHALL be an input of width DATAWIDTH carrying the write data.
REQ-008 The ports WVALID (input, 1) and WREADY (output, 1) SHALL form the write-data handshake.
REQ-009 The ports BVALID (output, 1) and BREADY (input, 1) SHALL form the write-response handshake.
REQ-010 The port ARADDR SHALL be an input of width ADDRWIDTH carrying the read address.
REQ-011 The ports ARVALID (input, 1) and ARREADY (output, 1) SHALL form the read-address handshake.
REQ-012 The port RDATA SHALL be an output of width DATAWIDTH carrying the read data.
REQ-013 The ports RVALID (output, 1) and RREADY (input, 1) SHALL form the read-data handshake.
REQ-014 The port REG_OUT SHALL be an output of width NREGS*DATAWIDTH exposing all registers, with register i at bits [i*DATAWIDTH +: DATAWIDTH].

Function
REQ-015 A handshake SHALL occur on a rising ACLK edge at which both VALID and READY of that channel are 1.
REQ-016 The register index SHALL be ADDR[2 +: log2(NREGS)]; ADDR[1:0] SHALL be ignored.
REQ-017 An address with any bit above the index field set SHALL be out of range.
REQ-018 The write FSM SHALL have states WR_IDLE, WR_HAVE_ADDR, WR_HAVE_DATA and WR_RESP.
REQ-019 The write outputs SHALL be registered: WR_IDLE gives AWREADY=1 and WREADY=1; WR_HAVE_ADDR gives AWREADY=0 and WREADY=1; WR_HAVE_DATA gives AWREADY=1 and WREADY=0; WR_RESP gives AWREADY=0, WREADY=0 and BVALID=1.
REQ-020 In WR_IDLE, simultaneous AW and W handshakes SHALL perform the write and move to WR_RESP; an AW handshake alone SHALL latch the address and move to WR_HAVE_ADDR; a W handshake alone SHALL latch the data and move to WR_HAVE_DATA.
REQ-021 In WR_HAVE_ADDR, a W handshake SHALL perform the write and move to WR_RESP; in WR_HAVE_DATA, an AW handshake SHALL do the same.
REQ-022 A write SHALL update the register on the edge of the completing handshake, and BVALID SHALL be 1 in the next cycle.
REQ-023 An out-of-range write SHALL change no register but SHALL still produce BVALID.
REQ-024 In WR_RESP, BVALID SHALL hold at 1 until a B handshake, which SHALL return the FSM to WR_IDLE with BVALID=0 in the next cycle.
REQ-025 The read FSM SHALL have states RD_IDLE (ARREADY=1, RVALID=0) and RD_DATA (ARREADY=0, RVALID=1).
REQ-026 An AR handshake in RD_IDLE SHALL capture the selected register into RDATA and move to RD_DATA, giving RVALID=1 in the next cycle.
REQ-027 An out-of-range read SHALL return RDATA=0.
REQ-028 RDATA SHALL stay stable while RVALID=1; an R handshake SHALL return the FSM to RD_IDLE.
REQ-029 The read and write FSMs SHALL run independently and concurrently.
REQ-030 When an AR handshake and a write to the same register complete on the same edge, RDATA SHALL return the pre-write value.
REQ-031 Throughput SHALL be at most one write per 2 cycles and one read per 2 cycles, with no combinational path from any input to any output.

Reset
REQ-032 While ARESET=1 at a rising edge, all registers, RDATA and REG_OUT SHALL become 0, AWREADY, WREADY, ARREADY, BVALID and RVALID SHALL become 0, and both FSMs SHALL enter their IDLE state.
REQ-033 The READY outputs SHALL first be 1 in the cycle after the first rising edge that samples ARESET=0.
REQ-034 Reset applied mid-transaction SHALL discard any latched address or data, SHALL perform no register write, and SHALL drop BVALID and RVALID.

Verification
REQ-035 The bench SHALL cover this case: AW 0x04 and W 0xDEADBEEF presented in the same cycle, BREADY=1 -> BVALID=1 one cycle later, REG_OUT[63:32]=0xDEADBEEF, then a read of 0x04 returns 0xDEADBEEF.
REQ-036 The bench SHALL cover this case: W 0x12345678 presented 3 cycles before AW 0x08 -> WREADY=0 and AWREADY=1 while waiting, register 2=0x12345678, exactly one BVALID.
REQ-037 The bench SHALL cover this case: write to 0x40 with NREGS=16 -> BVALID asserted, all registers unchanged, and a read of 0x40 returns 0.
REQ-038 The bench SHALL cover this case: RREADY held 0 for 5 cycles after an AR handshake -> RVALID=1 and RDATA stable for all 5 cycles, and ARREADY=0.
REQ-039 The bench SHALL cover this case: register 1=0xA, then a read of 0x04 and a write of 0xB to 0x04 complete on the same edge -> RDATA=0xA, then register 1=0xB.
REQ-040 The bench SHALL cover this case: ARESET pulsed in WR_HAVE_ADDR -> no register change, BVALID=0, and the READY outputs return 1 one cycle after reset release.

Source files
------------

// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite slave exposing NREGS word registers. The write and read channels
// run independent FSMs, and all handshake outputs are registered.
module axi4lite_slave_regfile #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32,
  parameter int NREGS     = 16
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [ADDRWIDTH-1:0]       AWADDR,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [DATAWIDTH-1:0]       WDATA,
  input  logic                       WVALID,
  output logic                       WREADY,
  output logic                       BVALID,
  input  logic                       BREADY,
  input  logic [ADDRWIDTH-1:0]       ARADDR,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [DATAWIDTH-1:0]       RDATA,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic [NREGS*DATAWIDTH-1:0] REG_OUT
);

  localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [1:0] {
    WR_IDLE      = 2'b00,
    WR_HAVE_ADDR = 2'b01,
    WR_HAVE_DATA = 2'b10,
    WR_RESP      = 2'b11
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

  // Any address bit above the register index field makes the access out of range.
  function automatic logic addr_in_range(input logic [ADDRWIDTH-1:0] addr);
    return (addr >> (2 + IDXW)) == '0;
  endfunction

  function automatic logic [IDXW-1:0] addr_index(input logic [ADDRWIDTH-1:0] addr);
    logic [ADDRWIDTH-1:0] word;
    word = addr >> 2;
    return word[IDXW-1:0];
  endfunction

  wr_state_e                        wr_state_q;
  rd_state_e                        rd_state_q;
  logic                             awready_q, wready_q, bvalid_q;
  logic                             arready_q, rvalid_q;
  logic [ADDRWIDTH-1:0]             awaddr_q;
  logic [DATAWIDTH-1:0]             wdata_q;
  logic [DATAWIDTH-1:0]             rdata_q;
  logic [NREGS-1:0][DATAWIDTH-1:0]  regs_q;

  logic                             aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic                             wr_fire_s;
  logic [ADDRWIDTH-1:0]             wr_addr_s;
  logic [DATAWIDTH-1:0]             wr_data_s;

  assign aw_hs_s = AWVALID & awready_q;
  assign w_hs_s  = WVALID  & wready_q;
  assign b_hs_s  = bvalid_q & BREADY;
  assign ar_hs_s = ARVALID & arready_q;
  assign r_hs_s  = rvalid_q & RREADY;

  // Select the address/data pair that completes a write on this edge.
  always_comb begin
    wr_fire_s = 1'b0;
    wr_addr_s = awaddr_q;
    wr_data_s = wdata_q;
    case (wr_state_q)
      WR_IDLE: begin
        wr_fire_s = aw_hs_s & w_hs_s;
        wr_addr_s = AWADDR;
        wr_data_s = WDATA;
      end
      WR_HAVE_ADDR: begin
        wr_fire_s = w_hs_s;
        wr_data_s = WDATA;
      end
      WR_HAVE_DATA: begin
        wr_fire_s = aw_hs_s;
        wr_addr_s = AWADDR;
      end
      default: wr_fire_s = 1'b0;
    endcase
  end

  // Write-channel FSM with registered ready/valid outputs.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_q <= WR_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
    end else begin
      case (wr_state_q)
        WR_IDLE: begin
          if (aw_hs_s && w_hs_s) begin
            wr_state_q <= WR_RESP;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
          end else if (aw_hs_s) begin
            awaddr_q   <= AWADDR;
            wr_state_q <= WR_HAVE_ADDR;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
          end else if (w_hs_s) begin
            wdata_q    <= WDATA;
            wr_state_q <= WR_HAVE_DATA;
            awready_q  <= 1'b1;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
          end else begin
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
          end
        end
        WR_HAVE_ADDR: begin
          if (w_hs_s) begin
            wr_state_q <= WR_RESP;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
          end else begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
          end
        end
        WR_HAVE_DATA: begin
          if (aw_hs_s) begin
            wr_state_q <= WR_RESP;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
          end else begin
            awready_q  <= 1'b1;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
          end
        end
        WR_RESP: begin
          if (b_hs_s) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
          end else begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
          end
        end
        default: begin
          wr_state_q <= WR_IDLE;
          awready_q  <= 1'b0;
          wready_q   <= 1'b0;
          bvalid_q   <= 1'b0;
        end
      endcase
    end
  end

  // Register file; out-of-range writes are acknowledged but dropped.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      regs_q <= '0;
    end else if (wr_fire_s && addr_in_range(wr_addr_s)) begin
      regs_q[addr_index(wr_addr_s)] <= wr_data_s;
    end
  end

  // Read-channel FSM; sampling regs_q here yields the pre-write value on a same-edge write.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (ar_hs_s) begin
            rdata_q    <= addr_in_range(ARADDR) ? regs_q[addr_index(ARADDR)] : '0;
            rd_state_q <= RD_DATA;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
          end else begin
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
          end
        end
        RD_DATA: begin
          if (r_hs_s) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
          end else begin
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
          end
        end
        default: begin
          rd_state_q <= RD_IDLE;
          arready_q  <= 1'b0;
          rvalid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign REG_OUT = regs_q;

endmodule
